// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth carry-save accumulator: digit
// encodings, default sizing and the controller state encoding.
package booth_pkg;

  localparam int DEF_WIDTH = 32;

  // Number of radix-4 digits needed to cover an operand extended by two bits
  function automatic int booth_ndig(input int width);
    return width / 2 + 1;
  endfunction

  localparam int DEF_NDIG = booth_ndig(DEF_WIDTH);

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } booth_digit_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/booth_pp_row.sv
// One radix-4 Booth partial-product row, unshifted. A negative digit is
// returned as the inverted magnitude plus a neg flag; the caller places the
// matching +1 at the row's weight so no carry-propagate negation is needed.
module booth_pp_row
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]         triplet,
  input  logic [WIDTH+1:0]   a_ext,
  output logic [2*WIDTH-1:0] row,
  output logic               neg
);

  localparam int RW = 2 * WIDTH;

  booth_digit_e      digit;
  logic [RW-1:0]     a_wide;

  assign a_wide = {{(RW - WIDTH - 2){a_ext[WIDTH+1]}}, a_ext};

  // Decode the overlapping bit triplet {b[2i+1], b[2i], b[2i-1]} into a digit
  always_comb begin
    digit = ZERO;
    case (triplet)
      3'b001, 3'b010: digit = P1;
      3'b011:         digit = P2;
      3'b100:         digit = M2;
      3'b101, 3'b110: digit = M1;
      default:        digit = ZERO;
    endcase
  end

  // Select the multiple of the multiplicand, inverting it for negative digits
  always_comb begin
    row = '0;
    neg = 1'b0;
    case (digit)
      P1: row = a_wide;
      P2: row = a_wide << 1;
      M1: begin
        row = ~a_wide;
        neg = 1'b1;
      end
      M2: begin
        row = ~(a_wide << 1);
        neg = 1'b1;
      end
      default: row = '0;
    endcase
  end

endmodule

// File: rtl/booth_csa_accumulator.sv
// Iterative radix-4 Booth multiplier front end. DPC partial products per cycle
// are folded into a carry-save sum/carry pair, which is handed to the final
// prefix adder on a valid/ready handshake once every digit has been consumed.
module booth_csa_accumulator
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DPC   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_sum,
  output logic [2*WIDTH-1:0] out_carry
);

  localparam int NDIG = booth_ndig(WIDTH);
  localparam int RW   = 2 * WIDTH;
  localparam int KW   = $clog2(NDIG + DPC + 1);

  state_e            state;
  state_e            next_state;

  logic [WIDTH+1:0]  a_q;
  logic [WIDTH+1:0]  b_q;
  logic [RW-1:0]     sum_q;
  logic [RW-1:0]     carry_q;
  logic [KW-1:0]     k_q;

  logic [WIDTH+1:0]  a_ext_in;
  logic [WIDTH+1:0]  b_ext_in;
  logic [WIDTH+2:0]  b_pad;

  logic [RW-1:0]     pp_rows  [DPC];
  logic [RW-1:0]     neg_bits [DPC];
  logic [RW-1:0]     neg_row;
  logic [RW-1:0]     st_sum   [DPC+2];
  logic [RW-1:0]     st_carry [DPC+2];

  // The signedness choice is folded into the stored operands at capture time
  assign a_ext_in = {{2{in_signed & in_a[WIDTH-1]}}, in_a};
  assign b_ext_in = {{2{in_signed & in_b[WIDTH-1]}}, in_b};
  assign b_pad    = {b_q, 1'b0};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = sum_q;
  assign out_carry = carry_q;

  // Per-digit partial products for digits k..k+DPC-1, placed at weight 4^digit
  for (genvar j = 0; j < DPC; j++) begin : g_digit
    logic [KW-1:0] idx;
    logic [KW:0]   shamt;
    logic          idx_ok;
    logic [2:0]    triplet;
    logic [RW-1:0] raw_row;
    logic          raw_neg;

    assign idx     = k_q + KW'(j);
    assign shamt   = {idx, 1'b0};
    assign idx_ok  = (int'(idx) < NDIG);
    assign triplet = 3'(b_pad >> shamt);

    booth_pp_row #(.WIDTH(WIDTH)) u_pp_row (
      .triplet (triplet),
      .a_ext   (a_q),
      .row     (raw_row),
      .neg     (raw_neg)
    );

    assign pp_rows[j]  = idx_ok ? (raw_row << shamt) : '0;
    assign neg_bits[j] = (idx_ok && raw_neg) ? (RW'(1) << shamt) : '0;
  end

  // Neg bits sit at distinct even positions, so they merge into one row by OR
  always_comb begin
    neg_row = '0;
    for (int j = 0; j < DPC; j++) begin
      neg_row = neg_row | neg_bits[j];
    end
  end

  // Chain of 3:2 full-adder columns folding each new row into sum/carry;
  // the carry out of the top column falls off, which is the mod 2^RW wrap
  assign st_sum[0]   = sum_q;
  assign st_carry[0] = carry_q;

  for (genvar j = 0; j <= DPC; j++) begin : g_csa
    logic [RW-1:0] z;
    logic [RW-1:0] maj;

    if (j < DPC) begin : g_pp
      assign z = pp_rows[j];
    end else begin : g_neg
      assign z = neg_row;
    end

    assign st_sum[j+1]   = st_sum[j] ^ st_carry[j] ^ z;
    assign maj           = (st_sum[j] & st_carry[j]) | (st_sum[j] & z) | (st_carry[j] & z);
    assign st_carry[j+1] = maj << 1;
  end

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: accumulate until the last digit group has been folded in
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = ACCUM;
      ACCUM:   if (int'(k_q) + DPC >= NDIG) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, carry-save accumulation and digit index advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      k_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a_ext_in;
            b_q     <= b_ext_in;
            sum_q   <= '0;
            carry_q <= '0;
            k_q     <= '0;
          end
        end
        ACCUM: begin
          sum_q   <= st_sum[DPC+1];
          carry_q <= st_carry[DPC+1];
          k_q     <= k_q + KW'(DPC);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_csa_accumulator.sv
// Scoreboard bench for booth_csa_accumulator. Three instances (DPC = 1, 4, 17)
// share the operand stream; each keeps its own queue of expected products and
// a monitor that checks product and latency whenever its rows are presented.
module tb_booth_csa_accumulator;

  typedef struct {
    logic [63:0] prod;
    int          acc_cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_signed;

  logic        in_ready_v  [3];
  logic        out_valid_v [3];
  logic        out_ready_v [3];
  logic [63:0] out_sum_v   [3];
  logic [63:0] out_carry_v [3];

  int checks;
  int errors;
  int cyc;
  int pending [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to measure latency
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact product by plain 64-bit arithmetic on the interpreted operands
  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
    longint xa;
    longint xb;
    xa = s ? longint'($signed(a)) : longint'({32'b0, a});
    xb = s ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(xa * xb);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D    = (g == 0) ? 1 : ((g == 1) ? 4 : 17);
    localparam int NLAT = (17 + D - 1) / D;

    exp_t        q [$];
    exp_t        item;
    logic [63:0] cur_prod;
    bit          seen;

    booth_csa_accumulator #(.WIDTH(32), .DPC(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[g]),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_signed (in_signed),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .out_sum   (out_sum_v[g]),
      .out_carry (out_carry_v[g])
    );

    // Push the expected product whenever this instance accepts operands
    always @(posedge clk) begin
      if (!rst_n) begin
        q.delete();
        pending[g] = 0;
      end else if (in_valid && in_ready_v[g]) begin
        q.push_back('{prod: refProduct(in_a, in_b, in_signed), acc_cyc: cyc});
        pending[g]++;
      end
    end

    // Pop on the first cycle rows appear; check the product every valid cycle
    initial seen = 1'b0;
    always @(negedge clk) begin
      if (!rst_n) begin
        seen = 1'b0;
      end else if (out_valid_v[g]) begin
        if (!seen) begin
          seen = 1'b1;
          if (q.size() == 0) begin
            checks++;
            errors++;
            cur_prod = 64'h0;
            $display("[TB] FAIL unexpected_output dpc=%0d actual=valid required=none", D);
          end else begin
            item     = q.pop_front();
            pending[g]--;
            cur_prod = item.prod;
            checkOutput($sformatf("latency_dpc%0d", D), 64'(cyc - item.acc_cyc - 1), 64'(NLAT));
          end
        end
        checkOutput($sformatf("product_dpc%0d", D), out_sum_v[g] + out_carry_v[g], cur_prod);
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready_v[1] && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("accept_ready", 64'(in_ready_v[1]), 64'd1);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic waitResult(input string name, input logic [63:0] req);
    int lat;
    lat = 0;
    while (!out_valid_v[1] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'd5);
    checkOutput({name, "_product"}, out_sum_v[1] + out_carry_v[1], req);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Directed sequence, then randomized traffic, then drain and summary
  initial begin
    logic [63:0] bp_prod;
    int          budget;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    for (int i = 0; i < 3; i++) out_ready_v[i] = 1'b1;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset_in_ready%0d", i), 64'(in_ready_v[i]), 64'd1);
      checkOutput($sformatf("reset_out_valid%0d", i), 64'(out_valid_v[i]), 64'd0);
    end
    checkOutput("reset_out_sum", out_sum_v[1], 64'd0);
    checkOutput("reset_out_carry", out_carry_v[1], 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    waitResult("umax_sq", 64'hFFFF_FFFE_0000_0001);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
    waitResult("smin_sq", 64'h4000_0000_0000_0000);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1);
    waitResult("smin_x1", 64'hFFFF_FFFF_8000_0000);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0005, 1'b1);
    waitResult("sneg1_x5", 64'hFFFF_FFFF_FFFF_FFFB);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0005, 1'b0);
    waitResult("umax_x5", 64'h0000_0004_FFFF_FFFB);

    // Backpressure: rows must hold while in_valid pulses are ignored
    @(negedge clk);
    for (int i = 0; i < 3; i++) out_ready_v[i] = 1'b0;
    bp_prod = refProduct(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    waitResult("bp", bp_prod);
    for (int n = 0; n < 10; n++) begin
      checkOutput("bp_out_valid", 64'(out_valid_v[1]), 64'd1);
      checkOutput("bp_in_ready", 64'(in_ready_v[1]), 64'd0);
      checkOutput("bp_rows", out_sum_v[1] + out_carry_v[1], bp_prod);
      in_valid  = 1'b1;
      in_a      = $urandom;
      in_b      = $urandom;
      in_signed = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) out_ready_v[i] = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", 64'(out_valid_v[1]), 64'd0);
    repeat (20) @(negedge clk);

    // Reset during the second accumulate cycle aborts the transaction
    applyStimulus(32'h0BAD_F00D, 32'h0123_4567, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 64'(out_valid_v[1]), 64'd0);
    checkOutput("abort_out_sum", out_sum_v[1], 64'd0);
    checkOutput("abort_out_carry", out_carry_v[1], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("abort_in_ready", 64'(in_ready_v[1]), 64'd1);
    @(negedge clk);
    applyStimulus(32'd3, 32'd7, 1'b0);
    waitResult("mul3x7", 64'd21);
    @(negedge clk);

    // Randomized traffic with random downstream backpressure
    for (int n = 0; n < 4000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = pickOperand();
      in_b      = pickOperand();
      in_signed = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) out_ready_v[i] = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) out_ready_v[i] = 1'b1;

    budget = 0;
    while ((pending[0] + pending[1] + pending[2]) != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("drain_pending%0d", i), 64'(pending[i]), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
